// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic unit: operation
// encodings and the control FSM state type.
package arith_pkg;

    // Operation select encodings carried on the op bus.
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_arith_unit_if.sv
// Request/response bundle of the sequential arithmetic unit.
//
// Handshake: the requester drives start with op/a/b. The unit accepts on a
// rising edge where it is idle (busy=0) and start=1; operands are captured at
// that edge. busy stays high from the cycle after accept until the unit is
// idle again; start is ignored while busy. done pulses for exactly one cycle
// when results are valid, and prd/quo/rem/dbz hold until the next accept
// (dbz clears at accept).
interface seq_arith_unit_if #(parameter int W = 8);
    import arith_pkg::*;

    logic           start;
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] prd;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;
    logic           dbz;
    state_t         dbg_state;

    modport master (
        output start, op, a, b,
        input  busy, done, prd, quo, rem, dbz, dbg_state
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, prd, quo, rem, dbz, dbg_state
    );

endinterface

// File: rtl/seq_divider_core.sv
// Restoring shift-subtract divider datapath: one quotient bit per step.
// Loading captures dividend/divisor; after W steps quo/rem hold the result.
// Divide-by-zero is handled by the caller and never stepped here.
module seq_divider_core #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem
);

    logic [W-1:0] q_r;
    logic [W-1:0] r_r;
    logic [W-1:0] d_r;
    logic [W:0]   shifted;
    logic [W:0]   diff;
    logic         fits;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign shifted = {r_r, q_r[W-1]};
    assign diff    = shifted - {1'b0, d_r};
    // shifted < 2*d always holds, so the top bit of diff is a clean borrow flag.
    assign fits    = ~diff[W];

    // Load operands, then shift one quotient bit into q_r per step.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_r <= '0;
            r_r <= '0;
            d_r <= '0;
        end else if (load) begin
            q_r <= dividend;
            r_r <= '0;
            d_r <= divisor;
        end else if (step) begin
            if (fits) begin
                r_r <= diff[W-1:0];
                q_r <= {q_r[W-2:0], 1'b1};
            end else begin
                r_r <= shifted[W-1:0];
                q_r <= {q_r[W-2:0], 1'b0};
            end
        end
    end

    assign quo = q_r;
    assign rem = r_r;

endmodule

// File: rtl/seq_arith_unit.sv
// Sequential arithmetic unit: ADD/SUB in one step, MUL by radix-2 shift-add
// and DIV by restoring division, each W steps. A final CALC cycle commits the
// working registers to the output registers on the way into DONE, so partial
// values never appear on prd/quo/rem.
module seq_arith_unit
    import arith_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    seq_arith_unit_if.slave  bus
);

    localparam int             CW     = $clog2(W + 1);
    localparam logic [CW-1:0]  ITER_W = CW'(W);
    localparam logic [CW-1:0]  ITER_1 = CW'(1);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  limit;
    logic [1:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] prd_q;
    logic [W-1:0]   quo_q;
    logic [W-1:0]   rem_q;
    logic           dbz_q;
    logic           busy_q;
    logic           done_q;
    logic           accept;
    logic           div_step;
    logic [W-1:0]   div_quo;
    logic [W-1:0]   div_rem;

    assign accept = (state == ST_IDLE) && bus.start;

    // Number of working steps for the latched operation.
    always_comb begin
        limit = ITER_1;
        if (op_q == OP_MUL || (op_q == OP_DIV && b_q != '0)) begin
            limit = ITER_W;
        end
    end

    assign div_step = (state == ST_CALC) && (op_q == OP_DIV) && (b_q != '0) && (cnt != limit);

    seq_divider_core #(.W(W)) u_div (
        .clk      (clk),
        .rstn     (rstn),
        .load     (accept),
        .step     (div_step),
        .dividend (bus.a),
        .divisor  (bus.b),
        .quo      (div_quo),
        .rem      (div_rem)
    );

    // Control FSM plus ADD/SUB/MUL datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_q   <= OP_ADD;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prd_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q   <= bus.op;
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        cnt    <= '0;
                        acc    <= '0;
                        mcand  <= {{W{1'b0}}, bus.a};
                        mplier <= bus.b;
                        dbz_q  <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (cnt == limit) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                        if (op_q == OP_DIV) begin
                            if (b_q == '0) begin
                                quo_q <= '1;
                                rem_q <= a_q;
                                dbz_q <= 1'b1;
                            end else begin
                                quo_q <= div_quo;
                                rem_q <= div_rem;
                            end
                        end else begin
                            prd_q <= acc;
                        end
                    end else begin
                        cnt <= cnt + ITER_1;
                        case (op_q)
                            OP_ADD: acc <= {{W{1'b0}}, a_q} + {{W{1'b0}}, b_q};
                            OP_SUB: acc <= {{W{1'b0}}, a_q} - {{W{1'b0}}, b_q};
                            OP_MUL: begin
                                if (mplier[0]) begin
                                    acc <= acc + mcand;
                                end
                                mcand  <= mcand << 1;
                                mplier <= mplier >> 1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.prd       = prd_q;
    assign bus.quo       = quo_q;
    assign bus.rem       = rem_q;
    assign bus.dbz       = dbz_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Bench for seq_arith_unit (W=8): directed cases plus random operations,
// scoreboard of expected results and done timing checked by a monitor.
module tb_seq_arith_unit;
    import arith_pkg::*;

    localparam int W = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    // Clock and reset
    always #5 clk = ~clk;

    seq_arith_unit_if #(.W(W)) bus();

    seq_arith_unit #(.W(W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [2*W-1:0] prd;
        logic [W-1:0]   quo;
        logic [W-1:0]   rem;
        logic           dbz;
        int             done_cyc;
        string          name;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: output registers as seen by the requester.
    logic [2*W-1:0] m_prd = '0;
    logic [W-1:0]   m_quo = '0;
    logic [W-1:0]   m_rem = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Compute expected outputs arithmetically and enqueue them. Called at the
    // falling edge just before the accepting rising edge.
    task automatic push_exp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input string nm);
        exp_t e;
        int   ai;
        int   bi;
        int   n;
        ai = int'(a);
        bi = int'(b);
        n  = 1;
        e.dbz = 1'b0;
        case (op)
            OP_ADD: m_prd = (2*W)'(ai + bi);
            OP_SUB: m_prd = (2*W)'(ai - bi);
            OP_MUL: begin
                m_prd = (2*W)'(ai * bi);
                n = W;
            end
            default: begin
                if (bi == 0) begin
                    m_quo = '1;
                    m_rem = a;
                    e.dbz = 1'b1;
                end else begin
                    m_quo = W'(ai / bi);
                    m_rem = W'(ai % bi);
                    n = W;
                end
            end
        endcase
        e.prd      = m_prd;
        e.quo      = m_quo;
        e.rem      = m_rem;
        e.done_cyc = cyc + n + 2;
        e.name     = nm;
        exp_q.push_back(e);
    endtask

    // Wait for idle (scrambling idle inputs meanwhile), then present one request.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string nm);
        int guard;
        guard = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && guard < 200) begin
            bus.op = 2'($urandom);
            bus.a  = W'($urandom);
            bus.b  = W'($urandom);
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            failures++;
            $display("FAIL %s_idle: busy still 1 after %0d cycles, required 0", nm, guard);
        end
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        push_exp(op, a, b, nm);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
    endtask

    // Monitor: compare every done pulse against the head of the scoreboard.
    logic prev_done = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn && bus.done === 1'b1) begin
                check("done_single_cycle", {31'd0, prev_done}, 32'd0);
                check("busy_with_done", {31'd0, bus.busy}, 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending op", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_prd"}, 32'(bus.prd), 32'(e.prd));
                    check({e.name, "_quo"}, 32'(bus.quo), 32'(e.quo));
                    check({e.name, "_rem"}, 32'(bus.rem), 32'(e.rem));
                    check({e.name, "_dbz"}, {31'd0, bus.dbz}, {31'd0, e.dbz});
                    check({e.name, "_latency"}, cyc, e.done_cyc);
                end
            end
            prev_done = bus.done;
        end
    end

    task automatic check_all_zero(input string nm);
        check({nm, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({nm, "_done"}, {31'd0, bus.done}, 32'd0);
        check({nm, "_prd"}, 32'(bus.prd), 32'd0);
        check({nm, "_quo"}, 32'(bus.quo), 32'd0);
        check({nm, "_rem"}, 32'(bus.rem), 32'd0);
        check({nm, "_dbz"}, {31'd0, bus.dbz}, 32'd0);
        check({nm, "_state"}, 32'(bus.dbg_state), 32'(ST_IDLE));
    endtask

    // Stimulus
    initial begin
        int guard;
        logic [1:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        bus.start = 1'b0;
        bus.op    = OP_ADD;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;

        issue(OP_MUL, 8'd47, 8'd7, "mul_47x7");
        issue(OP_MUL, 8'd255, 8'd255, "mul_255x255");
        issue(OP_DIV, 8'd200, 8'd7, "div_200_7");
        issue(OP_DIV, 8'd37, 8'd0, "div_37_0");
        issue(OP_DIV, 8'd9, 8'd3, "div_9_3");
        issue(OP_SUB, 8'd3, 8'd5, "sub_3_5");
        issue(OP_ADD, 8'd255, 8'd1, "add_255_1");
        issue(OP_DIV, 8'd255, 8'd1, "div_255_1");
        issue(OP_DIV, 8'd0, 8'd5, "div_0_5");
        issue(OP_MUL, 8'd0, 8'd200, "mul_0x200");

        // start held high through a MUL while operands churn; the next
        // request is accepted only once the unit is idle again.
        @(negedge clk);
        guard = 0;
        while (bus.busy !== 1'b0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a     = 8'd12;
        bus.b     = 8'd12;
        push_exp(OP_MUL, 8'd12, 8'd12, "mul_12x12_held");
        guard = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && guard < 50) begin
            bus.op = 2'($urandom);
            bus.a  = W'($urandom);
            bus.b  = W'($urandom);
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            failures++;
            $display("FAIL held_idle: busy still 1 after %0d cycles, required 0", guard);
        end
        bus.op = OP_ADD;
        bus.a  = 8'd1;
        bus.b  = 8'd2;
        push_exp(OP_ADD, 8'd1, 8'd2, "add_after_held");
        @(negedge clk);
        bus.start = 1'b0;

        // Reset in the middle of a DIV: no done, outputs cleared, start ignored.
        issue(OP_DIV, 8'd100, 8'd3, "div_aborted");
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        exp_q.delete();
        m_prd = '0;
        m_quo = '0;
        m_rem = '0;
        @(negedge clk);
        check_all_zero("mid_reset");
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a     = 8'd5;
        bus.b     = 8'd5;
        @(negedge clk);
        check("start_in_reset_busy", {31'd0, bus.busy}, 32'd0);
        bus.start = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        check("post_reset_busy", {31'd0, bus.busy}, 32'd0);
        issue(OP_DIV, 8'd9, 8'd3, "div_after_reset");

        // Random operations; divisor forced to zero now and then.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = W'($urandom_range(0, 255));
            rb  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 255));
            issue(rop, ra, rb, $sformatf("rand%0d", i));
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d results still pending, required 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_arith_unit.md
SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

Interface
REQ-001 Parameter W: default 8; operand width, legal range 4..32.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 rstn  input  1  reset; synchronous and active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-006 a  input  W  first operand (multiplicand/dividend), unsigned.
REQ-007 b  input  W  second operand (multiplier/divisor), unsigned.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; results valid from this cycle on.
REQ-010 prd  output  2W  ADD/SUB/MUL result.
REQ-011 quo  output  W  DIV quotient.
REQ-012 rem  output  W  DIV remainder.
REQ-013 dbz  output  1  divide-by-zero flag for the last DIV.

Function
REQ-014 FSM states: IDLE, CALC, DONE; IDLE->CALC on start=1; CALC->DONE when iteration count reaches its limit; DONE->IDLE unconditionally.
REQ-015 On accept (IDLE, start=1): op, a, b latched; later input changes SHALL NOT affect the result.
REQ-016 start while busy or in DONE SHALL be ignored (no queueing).
REQ-017 busy=1 in CALC and DONE, 0 in IDLE; done=1 only in DONE.
REQ-018 ADD: prd = zero-extended a+b (carry in bit W); CALC lasts 1 cycle.
REQ-019 SUB: prd = a-b as 2W-bit two's complement (sign-extended borrow); CALC lasts 1 cycle.
REQ-020 MUL: radix-2 shift-add, one multiplier bit per cycle, CALC lasts exactly W cycles; prd = a*b, no overflow possible.
REQ-021 DIV: restoring shift-subtract, one quotient bit per cycle, CALC lasts exactly W cycles; quo = a/b, rem = a%b.
REQ-022 DIV with b=0: CALC lasts 1 cycle; quo = all ones, rem = a, dbz=1.
REQ-023 Latency: accept at edge k -> done=1 in the cycle after edge k+N+1, N = CALC length per REQ-018..022 (MUL/DIV: k+W+1).
REQ-024 dbz cleared on every accept; set only per REQ-022.
REQ-025 prd/quo/rem SHALL be held from DONE until the next accept; prd not updated by DIV, quo/rem not updated by ADD/SUB/MUL.
REQ-026 Intermediate partial values SHALL NOT be visible on outputs before DONE.
REQ-027 Iteration counter width $clog2(W+1); no wrap within a legal operation.

Reset
REQ-028 rstn=0 at an edge: state IDLE, busy=0, done=0, prd=0, quo=0, rem=0, dbz=0, counter=0.
REQ-029 Reset mid-operation SHALL abort it with no done pulse; start sampled with rstn=0 SHALL be ignored.
REQ-030 No asynchronous reset path.

Structure
REQ-031 Shared package arith_pkg: op encoding constants, FSM state typedef.
REQ-032 One sub-module natural: seq_divider_core (restoring divide datapath, parametrised by W); MUL/ADD/SUB datapath stays in the top.

Verification (W=8)
REQ-033 MUL a=47, b=7, start 1 cycle -> prd=329, done one cycle, 9 cycles after accept edge.
REQ-034 MUL a=255, b=255 -> prd=65025; DIV a=200, b=7 -> quo=28, rem=4, dbz=0, same latency.
REQ-035 DIV a=37, b=0 -> after 2 cycles done, quo=255, rem=37, dbz=1; following DIV 9/3 -> dbz=0, quo=3, rem=0.
REQ-036 SUB a=3, b=5 -> prd=0xFFFE; ADD 255+1 -> prd=256; both done 2 cycles after accept.
REQ-037 start held high, a/b/op changed during MUL 12*12 -> prd=144, exactly one done, next op accepted only after return to IDLE.
REQ-038 rstn=0 at cycle 4 of DIV -> no done, all outputs 0, busy=0; new start after release completes normally.
